// File: rtl/intt_scale_sequencer.sv
// rtl/intt_scale_sequencer.sv - INTT output scaling by 2^-S mod q over one shared 2-cycle halving unit
module intt_scale_sequencer #(
    parameter int LOGQ      = 54,
    parameter int MAX_SHIFT = 17,
    parameter int CNTW      = 17,
    localparam int SW       = $clog2(MAX_SHIFT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LOGQ-1:0] q,
    input  logic            start,
    input  logic [SW-1:0]   shift_amt,
    input  logic [CNTW-1:0] num_coeffs,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] out_data,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, LOAD, ITER, OUT} state_t;

    state_t          state;
    logic [SW-1:0]   shift_r;
    logic [CNTW-1:0] remaining;
    logic [LOGQ-1:0] slot0;
    logic [LOGQ-1:0] slot1;
    logic            slot1_vld;
    logic            fill_sel;
    logic            out_sel;
    logic [SW:0]     iter_cnt;

    // Halving unit: stage 1 holds x or x+q (always even), stage 2 writes (sum>>1) back to the slot.
    logic            h_vld;
    logic            h_slot;
    logic [LOGQ:0]   h_sum;

    logic [LOGQ-1:0] inj;
    logic            last_iter;

    assign inj       = iter_cnt[0] ? slot1 : slot0;
    assign last_iter = (iter_cnt == ({shift_r, 1'b0} - (SW+1)'(1)));
    assign out_data  = out_valid ? (out_sel ? slot1 : slot0) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_r   <= '0;
            remaining <= '0;
            slot0     <= '0;
            slot1     <= '0;
            slot1_vld <= 1'b0;
            fill_sel  <= 1'b0;
            out_sel   <= 1'b0;
            iter_cnt  <= '0;
            h_vld     <= 1'b0;
            h_slot    <= 1'b0;
            h_sum     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done  <= 1'b0;
            h_vld <= 1'b0;
            if (h_vld) begin
                if (h_slot)
                    slot1 <= LOGQ'(h_sum >> 1);
                else
                    slot0 <= LOGQ'(h_sum >> 1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_r   <= shift_amt;
                        remaining <= num_coeffs;
                        if (num_coeffs == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            fill_sel <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        remaining <= remaining - CNTW'(1);
                        if (!fill_sel) begin
                            slot0     <= in_data;
                            slot1_vld <= 1'b0;
                            fill_sel  <= 1'b1;
                        end else begin
                            slot1     <= in_data;
                            slot1_vld <= 1'b1;
                        end
                        // Leave after slot1 fills, or after slot0 when it was the last coefficient.
                        if (fill_sel || remaining == CNTW'(1)) begin
                            in_ready <= 1'b0;
                            iter_cnt <= '0;
                            out_sel  <= 1'b0;
                            if (shift_r != '0) begin
                                state <= ITER;
                            end else begin
                                state     <= OUT;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                end
                ITER: begin
                    h_vld    <= !iter_cnt[0] || slot1_vld;
                    h_slot   <= iter_cnt[0];
                    h_sum    <= inj[0] ? ({1'b0, inj} + {1'b0, q}) : {1'b0, inj};
                    iter_cnt <= iter_cnt + (SW+1)'(1);
                    if (last_iter) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    // slot1's last halving result lands at the end of the first OUT cycle, before it is shown.
                    if (out_ready) begin
                        if (!out_sel && slot1_vld) begin
                            out_sel <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            slot1_vld <= 1'b0;
                            if (remaining != '0) begin
                                state    <= LOAD;
                                in_ready <= 1'b1;
                                fill_sel <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intt_scale_sequencer.sv
// tb/tb_intt_scale_sequencer.sv - self-checking bench for intt_scale_sequencer
module tb_intt_scale_sequencer;

    localparam int LOGQ      = 54;
    localparam int MAX_SHIFT = 17;
    localparam int CNTW      = 17;
    localparam int SW        = $clog2(MAX_SHIFT + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [LOGQ-1:0] q;
    logic            start;
    logic [SW-1:0]   shift_amt;
    logic [CNTW-1:0] num_coeffs;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] out_data;
    logic            busy;
    logic            done;

    intt_scale_sequencer #(.LOGQ(LOGQ), .MAX_SHIFT(MAX_SHIFT), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .q(q), .start(start), .shift_amt(shift_amt),
        .num_coeffs(num_coeffs), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [LOGQ-1:0] stim[$];
    logic [LOGQ-1:0] got[$];
    int iter_seen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // x * (2^-1)^s mod m, with 2^-1 = (m+1)/2 for odd m
    function automatic logic [LOGQ-1:0] model(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] m, input int s);
        logic [127:0] inv;
        logic [127:0] r;
        inv = (128'(m) + 128'd1) / 128'd2;
        r   = 128'(x);
        for (int i = 0; i < s; i++)
            r = (r * inv) % 128'(m);
        return r[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] rand_below(input logic [LOGQ-1:0] m);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return LOGQ'(r % 64'(m));
    endfunction

    task automatic run_job(input logic [LOGQ-1:0] qq, input int s, input int n,
                           input bit bp, input bit spur, input string tag);
        logic [LOGQ-1:0] inq[$];
        logic [LOGQ-1:0] expq[$];
        logic [LOGQ-1:0] hold_data;
        bit stalled;
        bit finished;
        int hold_left;
        int cyc;
        int last_out;
        inq = stim;
        got = {};
        iter_seen = 0;
        foreach (stim[i]) expq.push_back(model(stim[i], qq, s));
        @(negedge clk);
        q = qq;
        start = 1'b1;
        shift_amt = SW'(s);
        num_coeffs = CNTW'(n);
        hold_left = bp ? 5 : 0;
        stalled = 1'b0;
        hold_data = '0;
        finished = 1'b0;
        last_out = -1;
        cyc = 0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            start = spur && busy && ($urandom_range(2) == 0);
            shift_amt = SW'($urandom_range(MAX_SHIFT));
            num_coeffs = CNTW'($urandom_range(9));
            in_valid = (inq.size() > 0) && ($urandom_range(3) != 0);
            in_data = (inq.size() > 0) ? inq[0] : rand_below(qq);
            if (out_valid && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = bp ? ($urandom_range(1) == 1) : 1'b1;
            end
            if (stalled) begin
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_data"}, out_data, hold_data);
            end
            stalled = out_valid && !out_ready;
            hold_data = out_data;
            if (busy && !in_ready && !out_valid) iter_seen++;
            if (in_valid && in_ready) void'(inq.pop_front());
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                last_out = cyc;
            end
            if (done) begin
                chk({tag, "_done_busy"}, busy, 0);
                chk({tag, "_done_timing"}, cyc, last_out + 1);
                finished = 1'b1;
            end
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_finished"}, finished, 1);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk({tag, "_data"}, got[i], expq[i]);
        chk({tag, "_iter_cycles"}, iter_seen, ((n + 1) / 2) * 2 * s);
        @(negedge clk);
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_single_done"}, done, 0);
    endtask

    initial begin
        logic [LOGQ-1:0] qr;
        int it;
        int n_in;
        int sr;
        int nr;
        rst = 1'b1;
        q = LOGQ'(17);
        start = 1'b0;
        shift_amt = '0;
        num_coeffs = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;

        stim = {LOGQ'(5)};
        run_job(LOGQ'(17), 1, 1, 0, 0, "s1_single");
        if (got.size() > 0) chk("s1_value", got[0], 11);

        stim = {LOGQ'(5), LOGQ'(3)};
        run_job(LOGQ'(17), 4, 2, 0, 0, "s4_pair");
        if (got.size() > 1) begin
            chk("s4_first", got[0], 12);
            chk("s4_second", got[1], 14);
        end

        stim = {LOGQ'(1), LOGQ'(2), LOGQ'(3)};
        run_job(LOGQ'(17), 0, 3, 0, 0, "s0_three");
        for (int i = 0; i < got.size(); i++) chk("s0_value", got[i], i + 1);

        stim = {};
        run_job(LOGQ'(17), 2, 0, 0, 0, "empty_job");

        qr = (LOGQ'(1) << 53) + LOGQ'(5);
        stim = {};
        for (int i = 0; i < 4; i++) stim.push_back(rand_below(qr));
        run_job(qr, 17, 4, 0, 0, "bigq");
        for (int i = 0; i < got.size(); i++)
            chk("bigq_inverse", ((128'(got[i]) << 17) % 128'(qr)), stim[i]);

        stim = {};
        for (int i = 0; i < 5; i++) stim.push_back(rand_below(LOGQ'(17)));
        run_job(LOGQ'(17), 3, 5, 1, 1, "backpressure");

        for (int j = 0; j < 4; j++) begin
            qr = LOGQ'({$urandom, $urandom}) | LOGQ'(1);
            if (qr < LOGQ'(3)) qr = LOGQ'(3);
            sr = $urandom_range(MAX_SHIFT);
            nr = $urandom_range(1, 6);
            stim = {};
            for (int i = 0; i < nr; i++) stim.push_back(rand_below(qr));
            run_job(qr, sr, nr, $urandom_range(1) == 1, 1, "random_job");
        end

        // reset in the third ITER cycle
        @(negedge clk);
        q = LOGQ'(17);
        start = 1'b1;
        shift_amt = SW'(3);
        num_coeffs = CNTW'(2);
        it = 0;
        n_in = 0;
        for (int c = 0; c < 100 && it < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b1;
            in_data = (n_in == 0) ? LOGQ'(5) : LOGQ'(3);
            if (in_valid && in_ready) n_in++;
            if (busy && !in_ready && !out_valid) it++;
        end
        chk("rst_reached_iter", it, 3);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_out_data", out_data, 0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("postrst_no_done", done, 0);
            chk("postrst_idle", busy, 0);
        end
        stim = {LOGQ'(5)};
        run_job(LOGQ'(17), 1, 1, 0, 0, "after_rst");
        if (got.size() > 0) chk("after_rst_value", got[0], 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intt_scale_sequencer.md
INTT_SCALE_SEQUENCER -- requirements
Module: intt_scale_sequencer

Interface
REQ-001 Parameter LOGQ, default 54: coefficient and modulus width in bits.
REQ-002 Parameter MAX_SHIFT, default 17: largest supported scaling exponent S.
REQ-003 Parameter CNTW, default 17: width of the coefficient-count port.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 q  in  LOGQ  odd modulus; held stable while busy.
REQ-007 start  in  1  one-cycle job start; sampled only in IDLE.
REQ-008 shift_amt  in  $clog2(MAX_SHIFT+1)  exponent S; latched on accepted start.
REQ-009 num_coeffs  in  CNTW  job length; latched on accepted start.
REQ-010 in_valid / in_ready / in_data  in / out / in[LOGQ]  input coefficient stream; transfer when valid&&ready.
REQ-011 out_valid / out_ready / out_data  out / in / out[LOGQ]  output coefficient stream; transfer when valid&&ready.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at job completion.

Function
REQ-014 Each output SHALL equal in_data·2^(-S) mod q, for in_data < q.
REQ-015 The block SHALL instantiate exactly one 2-cycle modular halving datapath (x -> x·2^(-1) mod q, latency 2) and time-share it across two coefficient slots (slot0, slot1).
REQ-016 The FSM SHALL have states IDLE, LOAD, ITER, OUT.
REQ-017 IDLE: start=1 latches S and num_coeffs into remaining; next state is LOAD, or IDLE with a done pulse the next cycle when num_coeffs=0.
REQ-018 start while busy SHALL be ignored with no side effects.
REQ-019 LOAD: in_ready=1. Slot0 fills first, then slot1. Each accepted transfer decrements remaining.
REQ-020 LOAD exit: taken after slot1 fills, or after slot0 fills with remaining=0 (odd tail; slot1 marked invalid). Next state is ITER if S>0, else OUT.
REQ-021 ITER SHALL last exactly 2·S cycles.
  - slot0 injected in even cycles, slot1 in odd cycles.
  - Each result is written back to its own slot 2 cycles after injection.
  - An invalid slot1 still occupies its cycle; its result is discarded.
REQ-022 OUT: out_valid=1 presenting slot0, then slot1 if valid. Order is preserved. in_ready=0.
REQ-023 Under backpressure (out_valid=1, out_ready=0), out_data SHALL hold stable and the FSM SHALL hold.
REQ-024 OUT exit after the last valid slot transfers:
  - remaining>0: go to LOAD.
  - remaining=0: go to IDLE, with done=1 for exactly that first IDLE cycle (busy=0 in that cycle).
REQ-025 in_ready SHALL be 0 in IDLE, ITER and OUT; out_valid SHALL be 0 outside OUT.
REQ-026 S>MAX_SHIFT is illegal; behaviour is unspecified.

Reset
REQ-027 rst=1 from any state SHALL, on the next edge, force:
  - state=IDLE, both slots invalid, remaining=0;
  - busy=0, done=0, in_ready=0, out_valid=0, out_data=0.
REQ-028 Reset mid-job SHALL discard in-flight data; halving-unit results landing after reset SHALL be ignored.
REQ-029 After reset release, the first start SHALL be accepted normally.

Verification
REQ-030 q=17, S=1, num_coeffs=1, in=5 -> single output 11; done one cycle after the output transfer.
REQ-031 q=17, S=4, num_coeffs=2, in=5,3 -> outputs 12 then 14, in order; ITER lasts exactly 8 cycles.
REQ-032 q=17, S=0, num_coeffs=3, in=1,2,3 -> outputs 1,2,3; second LOAD accepts one coefficient; no ITER cycles.
REQ-033 q=2^53+5 (LOGQ=54), S=17, 4 random inputs < q -> each output times 2^17 mod q equals its input.
REQ-034 out_ready=0 for 5 cycles in OUT -> out_data stable, no loss or duplication; start pulses during the job ignored.
REQ-035 rst asserted in the 3rd ITER cycle -> busy=0 and out_valid=0 next cycle, no done pulse; a following job with q=17, S=1, in=5 yields 11.
